gray_counter: RTL and testbench

- Registered up/down counter that emits its count as Gray code. It is the source stage feeding the existing Gray-to-binary converter and any Gray-encoded pointer or position path.
- Keeps a binary count internally and registers the Gray-encoded output.
- Supports load, clear, enable, wrap or saturate mode, a terminal-count flag and a valid/ready output handshake.

---
 rtl/gray_pkg.sv | 12 +
 rtl/binary_gray.sv | 26 ++
 rtl/gray_counter.sv | 85 ++++++++
 tb/tb_gray_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter and its encoder.
// bin2gray works on the widest supported code; narrower users zero-extend.
package gray_pkg;

  localparam int GRAY_WIDTH_MIN = 2;
  localparam int GRAY_WIDTH_MAX = 32;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/binary_gray.sv
// Combinational binary-to-Gray encoder; inverse of the Gray-to-binary converter.
module binary_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [GRAY_WIDTH_MAX-1:0] bin_ext;
  logic [GRAY_WIDTH_MAX-1:0] gray_ext;

  // Zero-extension leaves the low WIDTH bits of the code unchanged.
  assign bin_ext  = GRAY_WIDTH_MAX'(bin);
  assign gray_ext = bin2gray(bin_ext);
  assign gray     = gray_ext[WIDTH-1:0];

  generate
    if (WIDTH < GRAY_WIDTH_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^gray_ext[GRAY_WIDTH_MAX-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered Gray-coded output, load/clear, wrap or
// saturate ends, terminal-count flag and a valid/ready output handshake.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam bit               SAT      = (SATURATE != 0);

  generate
    if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
      $error("gray_counter: WIDTH out of supported range");
    end
  endgenerate

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             valid_d;
  logic             adv;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (bin_q == CNT_MAX);
  assign at_zero = (bin_q == CNT_ZERO);
  assign adv     = en && (!out_valid || out_ready);
  assign tc      = up ? at_max : at_zero;

  always_comb begin
    bin_d   = bin_q;
    valid_d = out_valid;
    if (clr) begin
      bin_d   = CNT_ZERO;
      valid_d = 1'b1;
    end else if (load) begin
      bin_d   = load_val;
      valid_d = 1'b1;
    end else if (adv) begin
      // A saturated hold still re-presents the code as a fresh transfer.
      valid_d = 1'b1;
      if (up) begin
        if (!(SAT && at_max)) bin_d = bin_q + WIDTH'(1);
      end else begin
        if (!(SAT && at_zero)) bin_d = bin_q - WIDTH'(1);
      end
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  binary_gray #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  // gray is registered from the encoded next count so it always tracks bin_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      gray      <= '0;
      out_valid <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray      <= gray_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: wrap and saturate instances share stimulus and are
// checked against directed vectors and an arithmetic reference count.
module tb_gray_counter;

  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         out_ready = 1'b0;
  logic [W-1:0] gray0, gray1;
  logic         v0, v1, tc0, tc1;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .gray(gray0), .out_valid(v0), .out_ready(out_ready), .tc(tc0)
  );

  gray_counter #(.WIDTH(W), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .gray(gray1), .out_valid(v1), .out_ready(out_ready), .tc(tc1)
  );

  int checks = 0;
  int errors = 0;

  int           mc[2];
  bit           mv;
  bit           stepped[2];
  logic [W-1:0] prev_g[2];

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         up;
    logic         rdy;
    logic [W-1:0] g0;
    logic [W-1:0] g1;
    logic         v;
    logic         t0;
    logic         t1;
  } vec_t;

  vec_t tbl[19];
  int   seq1[17];

  // The downstream Gray-to-binary converter.
  function automatic int g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit adv;
    adv = en && (!mv || out_ready);
    for (int s = 0; s < 2; s++) begin
      stepped[s] = 1'b0;
      if (clr) mc[s] = 0;
      else if (load) mc[s] = int'(load_val);
      else if (adv) begin
        if (up) begin
          if (!(s == 1 && mc[s] == M)) begin
            mc[s] = (mc[s] + 1) % (M + 1);
            stepped[s] = 1'b1;
          end
        end else begin
          if (!(s == 1 && mc[s] == 0)) begin
            mc[s] = (mc[s] + M) % (M + 1);
            stepped[s] = 1'b1;
          end
        end
      end
    end
    if (clr || load || adv) mv = 1'b1;
    else if (mv && out_ready) mv = 1'b0;
  endtask

  task automatic check_model();
    logic [W-1:0] g;
    logic         v, t;
    for (int s = 0; s < 2; s++) begin
      g = (s == 0) ? gray0 : gray1;
      v = (s == 0) ? v0 : v1;
      t = (s == 0) ? tc0 : tc1;
      chk(s == 0 ? "count_wrap" : "count_sat", g2b(g), mc[s]);
      chk(s == 0 ? "valid_wrap" : "valid_sat", int'(v), int'(mv));
      chk(s == 0 ? "tc_wrap" : "tc_sat", int'(t), int'(up ? (mc[s] == M) : (mc[s] == 0)));
      if (stepped[s]) chk("one_bit_step", $countones(g ^ prev_g[s]), 1);
      prev_g[s] = g;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr = 0; load = 0; en = 0; out_ready = 0; up = 1;
    mc[0] = 0; mc[1] = 0; mv = 1'b0;
    stepped[0] = 0; stepped[1] = 0;
    #2;
    chk("rst_gray0", int'(gray0), 0);
    chk("rst_valid0", int'(v0), 0);
    chk("rst_gray1", int'(gray1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_g[0] = gray0;
    prev_g[1] = gray1;
  endtask

  initial begin
    seq1 = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    //          clr load lv en up rdy  g0  g1  v  t0 t1
    tbl[0]  = '{0, 0, 4'd0,  1, 1, 1, 4'b0001, 4'b0001, 1, 0, 0};
    tbl[1]  = '{0, 0, 4'd0,  1, 1, 1, 4'b0011, 4'b0011, 1, 0, 0};
    tbl[2]  = '{0, 0, 4'd0,  1, 1, 1, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[3]  = '{0, 0, 4'd0,  1, 1, 0, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[4]  = '{0, 0, 4'd0,  1, 1, 0, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[5]  = '{0, 0, 4'd0,  1, 1, 0, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[6]  = '{0, 0, 4'd0,  1, 1, 0, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[7]  = '{0, 0, 4'd0,  1, 1, 0, 4'b0010, 4'b0010, 1, 0, 0};
    tbl[8]  = '{0, 0, 4'd0,  1, 1, 1, 4'b0110, 4'b0110, 1, 0, 0};
    tbl[9]  = '{1, 1, 4'd9,  1, 1, 1, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[10] = '{0, 1, 4'd9,  0, 1, 1, 4'b1101, 4'b1101, 1, 0, 0};
    tbl[11] = '{0, 0, 4'd0,  0, 1, 1, 4'b1101, 4'b1101, 0, 0, 0};
    tbl[12] = '{0, 0, 4'd0,  0, 1, 1, 4'b1101, 4'b1101, 0, 0, 0};
    tbl[13] = '{0, 1, 4'd14, 0, 1, 1, 4'b1001, 4'b1001, 1, 0, 0};
    tbl[14] = '{0, 0, 4'd0,  1, 1, 1, 4'b1000, 4'b1000, 1, 1, 1};
    tbl[15] = '{0, 0, 4'd0,  1, 1, 1, 4'b0000, 4'b1000, 1, 0, 1};
    tbl[16] = '{0, 0, 4'd0,  1, 1, 1, 4'b0001, 4'b1000, 1, 0, 1};
    tbl[17] = '{0, 0, 4'd0,  1, 0, 1, 4'b0000, 4'b1001, 1, 1, 0};
    tbl[18] = '{0, 0, 4'd0,  1, 0, 1, 4'b1000, 4'b1011, 1, 0, 0};

    // Full up-count with wrap on the wrapping instance.
    do_reset();
    en = 1; up = 1; out_ready = 1;
    chk("seq_start", int'(gray0), seq1[0]);
    for (int i = 1; i < 17; i++) begin
      tick();
      chk("seq_gray", int'(gray0), seq1[i]);
      chk("seq_tc", int'(tc0), int'(gray0 == 4'b1000));
    end

    // Down from reset; tc flags count 0 when counting down.
    do_reset();
    up = 0;
    #1;
    chk("tc_rst_down", int'(tc0), 1);
    up = 1;
    #1;
    chk("tc_rst_up", int'(tc0), 0);
    up = 0; en = 1; out_ready = 1;
    tick();
    chk("down_first", int'(gray0), 4'b1000);
    tick();
    chk("down_second", int'(gray0), 4'b1001);

    // Directed vectors: back-pressure, clr/load priority, saturation.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      clr = tbl[i].clr; load = tbl[i].load; load_val = tbl[i].lv;
      en = tbl[i].en; up = tbl[i].up; out_ready = tbl[i].rdy;
      tick();
      chk("vec_g0", int'(gray0), int'(tbl[i].g0));
      chk("vec_g1", int'(gray1), int'(tbl[i].g1));
      chk("vec_valid", int'(v0), int'(tbl[i].v));
      chk("vec_t0", int'(tc0), int'(tbl[i].t0));
      chk("vec_t1", int'(tc1), int'(tbl[i].t1));
    end

    // Asynchronous reset between edges, then first step after release.
    clr = 0; load = 0; en = 1; up = 1; out_ready = 1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gray0", int'(gray0), 0);
    chk("async_valid0", int'(v0), 0);
    chk("async_gray1", int'(gray1), 0);
    chk("async_valid1", int'(v1), 0);
    mc[0] = 0; mc[1] = 0; mv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_g[0] = gray0;
    prev_g[1] = gray1;
    tick();
    chk("after_rst_step", int'(gray0), 4'b0001);

    // Randomized traffic against the reference count.
    for (int i = 0; i < 600; i++) begin
      clr       = ($urandom_range(0, 19) == 0);
      load      = ($urandom_range(0, 9) == 0);
      load_val  = W'($urandom_range(0, M));
      en        = ($urandom_range(0, 3) != 0);
      up        = ($urandom_range(0, 4) != 0) ? (i % 160 < 80) : ~(i % 160 < 80);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
